// File: rtl/addr_stepper.sv
// Manual debug address generator: synchronised, debounced push buttons step `number` by +/-STEP, auto-repeat on hold, clear on a two-button chord.
// Latency: a clean press shows on `pressed` DB_CYCLES+2 cycles after the first high sample, and on `number` one cycle later.
// Backpressure: none; free-running, and all outputs are registered.
module addr_stepper #(
    parameter int ADDR_W        = 12,
    parameter int STEP          = 4,
    parameter int DB_CYCLES     = 100000,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        btn,
    output logic [ADDR_W-1:0] number,
    output logic              step_pulse,
    output logic [1:0]        pressed
);

    localparam int DB_W    = $clog2(DB_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0]  DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [ADDR_W-1:0] STEP_V      = ADDR_W'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        CHORD
    } state_t;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [DB_W-1:0] db_cnt [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // A level is accepted only after DB_CYCLES consecutive differing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign pressed = stable;

    state_t             state;
    state_t             state_nxt;
    logic               dir;
    logic               dir_nxt;
    logic [RPT_W-1:0]   rpt_cnt;
    logic [RPT_W-1:0]   rpt_nxt;
    logic [ADDR_W-1:0]  number_nxt;
    logic               pulse_nxt;
    logic               both;
    logic               any;
    logic               held;
    logic [ADDR_W-1:0]  stepped;

    // dir = 1 means decrement (btn[1]); latched when a hold starts.
    assign both    = &stable;
    assign any     = |stable;
    assign held    = stable[dir];
    assign stepped = dir ? (number - STEP_V) : (number + STEP_V);

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        rpt_nxt    = rpt_cnt;
        number_nxt = number;
        pulse_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (both) begin
                    number_nxt = '0;
                    pulse_nxt  = 1'b1;
                    state_nxt  = CHORD;
                end else if (any) begin
                    dir_nxt    = stable[1];
                    number_nxt = stable[1] ? (number - STEP_V) : (number + STEP_V);
                    pulse_nxt  = 1'b1;
                    rpt_nxt    = DELAY_LOAD;
                    state_nxt  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (both) begin
                    number_nxt = '0;
                    pulse_nxt  = 1'b1;
                    state_nxt  = CHORD;
                end else if (!held) begin
                    state_nxt = IDLE;
                end else if (rpt_cnt == '0) begin
                    number_nxt = stepped;
                    pulse_nxt  = 1'b1;
                    rpt_nxt    = PERIOD_LOAD;
                    state_nxt  = REPEAT;
                end else begin
                    rpt_nxt = rpt_cnt - RPT_W'(1);
                end
            end
            CHORD: begin
                // Wait for a full release so a partial re-press cannot step.
                if (!any) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= 1'b0;
            rpt_cnt    <= '0;
            number     <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            dir        <= dir_nxt;
            rpt_cnt    <= rpt_nxt;
            number     <= number_nxt;
            step_pulse <= pulse_nxt;
        end
    end

endmodule
